sequence_pattern_tx: RTL and testbench

//  Serial pattern transmitter: accepts SEQ_LEN-bit patterns over a valid/ready port, queues them,
//  and shifts each out MSB-first, one bit per clk, on a single serial line.

---
 rtl/sequence_pattern_tx_pkg.sv | 13 +
 rtl/sequence_pattern_tx_if.sv | 16 +
 rtl/sequence_pattern_tx_pattern_fifo.sv | 46 ++++
 rtl/sequence_pattern_tx.sv | 123 ++++++++++++
 tb/tb_sequence_pattern_tx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sequence_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding,
// default frame length and frame counter width.
package sequence_pattern_tx_pkg;

  localparam int SEQ_LEN_DEF = 4;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sequence_pattern_tx_if.sv
// Pattern input port of the serial transmitter: valid/ready handshake carrying
// one SEQ_LEN-bit pattern per transfer.
interface sequence_pattern_tx_if
  import sequence_pattern_tx_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF
);

  logic               pat_valid;
  logic [SEQ_LEN-1:0] pat_data;
  logic               pat_ready;

  modport master (output pat_valid, output pat_data, input  pat_ready);
  modport slave  (input  pat_valid, input  pat_data, output pat_ready);

endinterface

// File: rtl/sequence_pattern_tx_pattern_fifo.sv
// Show-ahead synchronous FIFO holding queued patterns; pointers carry an extra
// wrap bit so full and empty are distinguished without an occupancy counter.
module pattern_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset: entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sequence_pattern_tx.sv
// Serial pattern transmitter: queues SEQ_LEN-bit patterns and shifts each one
// out MSB-first, back-to-back, with first/last frame markers and a frame count.
module sequence_pattern_tx
  import sequence_pattern_tx_pkg::*;
#(
  parameter int   SEQ_LEN    = SEQ_LEN_DEF,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  sequence_pattern_tx_if.slave   pat,
  output logic                   out,
  output logic                   out_valid,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frames_sent
);

  localparam int             CNT_W    = $clog2(SEQ_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SEQ_LEN);

  state_t                 state, state_n;
  logic [SEQ_LEN-1:0]     shreg, shreg_n;
  logic [SEQ_LEN-1:0]     head;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
  logic                   out_n, valid_n, first_n;
  logic [FRAME_CNT_W-1:0] frames_n;
  logic                   full, empty, pop;

  pattern_fifo #(
    .WIDTH (SEQ_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pat.pat_valid),
    .wr_data (pat.pat_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign pat.pat_ready = !full;
  assign out_last      = (state == S_SHIFT) && (bit_cnt == LAST_CNT);
  assign busy          = (state == S_SHIFT) || !empty;

  // bit_cnt counts the bits already placed on `out`, so the frame ends on the
  // edge where it equals SEQ_LEN; a waiting pattern is loaded on that same edge.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    out_n     = out;
    valid_n   = out_valid;
    first_n   = out_first;
    frames_n  = frames_sent;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          out_n     = head[SEQ_LEN-1];
          shreg_n   = {head[SEQ_LEN-2:0], 1'b0};
          bit_cnt_n = CNT_W'(1);
          valid_n   = 1'b1;
          first_n   = 1'b1;
          state_n   = S_SHIFT;
        end else begin
          out_n   = IDLE_BIT;
          valid_n = 1'b0;
          first_n = 1'b0;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == LAST_CNT) begin
          frames_n = frames_sent + FRAME_CNT_W'(1);
          if (!empty) begin
            pop       = 1'b1;
            out_n     = head[SEQ_LEN-1];
            shreg_n   = {head[SEQ_LEN-2:0], 1'b0};
            bit_cnt_n = CNT_W'(1);
            valid_n   = 1'b1;
            first_n   = 1'b1;
          end else begin
            out_n   = IDLE_BIT;
            valid_n = 1'b0;
            first_n = 1'b0;
            state_n = S_IDLE;
          end
        end else begin
          out_n     = shreg[SEQ_LEN-1];
          shreg_n   = {shreg[SEQ_LEN-2:0], 1'b0};
          bit_cnt_n = bit_cnt + CNT_W'(1);
          first_n   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      out         <= IDLE_BIT;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      frames_sent <= '0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      out         <= out_n;
      out_valid   <= valid_n;
      out_first   <= first_n;
      frames_sent <= frames_n;
    end
  end

endmodule

// File: tb/tb_sequence_pattern_tx.sv
// Scoreboard bench for sequence_pattern_tx: every accepted pattern expands into
// expected serial bits that are checked as the DUT shifts them out.
module tb_sequence_pattern_tx;

  localparam int SEQ_LEN = 4;

  logic       clk;
  logic       rst;
  logic       out, out_valid, out_first, out_last, busy;
  logic [7:0] frames_sent;

  sequence_pattern_tx_if #(.SEQ_LEN(SEQ_LEN)) pat_if ();

  sequence_pattern_tx #(
    .SEQ_LEN    (SEQ_LEN),
    .FIFO_DEPTH (4),
    .IDLE_BIT   (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pat         (pat_if.slave),
    .out         (out),
    .out_valid   (out_valid),
    .out_first   (out_first),
    .out_last    (out_last),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         nChecks = 0;
  int         nBad = 0;
  logic [2:0] sb[$];
  int         expFrames = 0;
  logic       monEn = 1'b0;
  logic       prevValid = 1'b0;
  int         runLen = 0;
  int         maxRun = 0;
  int         accepted = 0;
  int         stallMark = -1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Each accepted pattern becomes SEQ_LEN expected {bit, first, last} entries.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      expFrames = 0;
    end else if (pat_if.pat_valid && pat_if.pat_ready) begin
      for (int i = SEQ_LEN - 1; i >= 0; i--)
        sb.push_back({pat_if.pat_data[i], (i == SEQ_LEN - 1), (i == 0)});
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (monEn) begin
      checkOutput("frames", {24'd0, frames_sent}, expFrames & 255);
      checkOutput("busy", busy, sb.size() != 0);
      if (sb.size() == 0) checkOutput("spurious", out_valid, 0);
      else if (prevValid) checkOutput("gap", out_valid, 1);
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("bit", out, e[2]);
        checkOutput("first", out_first, e[1]);
        checkOutput("last", out_last, e[0]);
        if (e[0]) expFrames++;
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        checkOutput("idleOut", out, 0);
        checkOutput("idleFirst", out_first, 0);
        checkOutput("idleLast", out_last, 0);
        runLen = 0;
      end
      prevValid = out_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pattern was accepted.
  task automatic applyStimulus(input logic [SEQ_LEN-1:0] p);
    pat_if.pat_valid = 1'b1;
    pat_if.pat_data  = p;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (pat_if.pat_ready) begin
        pat_if.pat_data = p;
        @(posedge clk);
        #1;
        pat_if.pat_valid = 1'b0;
        pat_if.pat_data  = SEQ_LEN'($urandom);
        accepted++;
        return;
      end
      if (stallMark < 0) stallMark = accepted;
      pat_if.pat_data = SEQ_LEN'($urandom);
    end
    checkOutput("pushTimeout", 0, 1);
    pat_if.pat_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1;
    end
    if (!done) checkOutput("idleTimeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    pat_if.pat_valid = 1'b0;
    pat_if.pat_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    monEn = 1'b1;

    @(negedge clk);
    checkOutput("rstOut", out, 0);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstFirst", out_first, 0);
    checkOutput("rstLast", out_last, 0);
    checkOutput("rstFrames", frames_sent, 0);
    checkOutput("rstReady", pat_if.pat_ready, 1);
    checkOutput("rstBusy", busy, 0);
    @(posedge clk);
    #1;

    $display("[TB] single frame and latency");
    applyStimulus(4'b1101);
    @(negedge clk);
    checkOutput("lat0Valid", out_valid, 0);
    @(negedge clk);
    checkOutput("lat1Valid", out_valid, 1);
    checkOutput("lat1Out", out, 1);
    checkOutput("lat1First", out_first, 1);
    waitIdle();
    checkOutput("t1Frames", frames_sent, 1);
    checkOutput("t1Out", out, 0);
    checkOutput("t1Valid", out_valid, 0);

    $display("[TB] back-to-back frames");
    base   = expFrames;
    maxRun = 0;
    applyStimulus(4'b1101);
    applyStimulus(4'b0010);
    applyStimulus(4'b1001);
    applyStimulus(4'b1110);
    waitIdle();
    checkOutput("run16", maxRun, 16);
    checkOutput("t2Frames", frames_sent, (base + 4) & 255);

    $display("[TB] backpressure");
    accepted  = 0;
    stallMark = -1;
    applyStimulus(4'b0001);
    applyStimulus(4'b0011);
    applyStimulus(4'b0111);
    applyStimulus(4'b1111);
    applyStimulus(4'b1010);
    applyStimulus(4'b0101);
    checkOutput("fullAfter", stallMark, 5);
    waitIdle();

    $display("[TB] push on pop edge at depth-1");
    applyStimulus(4'b1000);
    applyStimulus(4'b0100);
    applyStimulus(4'b1100);
    applyStimulus(4'b0110);
    @(posedge clk);
    #1;
    applyStimulus(4'b1011);
    @(negedge clk);
    checkOutput("t5Ready", pat_if.pat_ready, 1);
    checkOutput("t5First", out_first, 1);
    @(posedge clk);
    #1;
    applyStimulus(4'b0111);
    @(negedge clk);
    checkOutput("t5Full", pat_if.pat_ready, 0);
    waitIdle();

    $display("[TB] reset mid-frame");
    applyStimulus(4'b0010);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4Out", out, 0);
    checkOutput("t4Valid", out_valid, 0);
    checkOutput("t4Busy", busy, 0);
    checkOutput("t4Frames", frames_sent, 0);
    checkOutput("t4Ready", pat_if.pat_ready, 1);
    @(posedge clk);
    #1;
    applyStimulus(4'b1101);
    waitIdle();
    checkOutput("t4After", frames_sent, 1);

    $display("[TB] frame counter wrap");
    for (int i = 0; i < 255; i++) applyStimulus(SEQ_LEN'($urandom_range(0, 15)));
    waitIdle();
    checkOutput("wrap", frames_sent, 0);
    checkOutput("wrapBusy", busy, 0);

    monEn = 1'b0;
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
